exe_alu_status: RTL and testbench

//   Execute-stage consumer of the decoder's exe_cmd/S/wb/mem controls. Performs
//   the ALU operation and holds the NZCV status register, updated only by S=1
//   ops. Registers the result and pass-through controls into the EXE/MEM

---
 rtl/exe_alu_status_if.sv | 40 ++++
 rtl/exe_alu_status.sv | 129 ++++++++++++
 tb/tb_exe_alu_status.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/exe_alu_status_if.sv
// EXE-stage bundle: decoder controls/operands in, EXE/MEM pipeline register and NZCV out.
interface exe_alu_status_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_BITS = 4
);
  logic                freeze;
  logic                flush;
  logic                valid_in;
  logic [3:0]          exe_cmd;
  logic                s_in;
  logic                wb_en_in;
  logic                mem_read_in;
  logic                mem_write_in;
  logic [REG_BITS-1:0] dest_in;
  logic [WIDTH-1:0]    val_rn;
  logic [WIDTH-1:0]    val_2;

  logic [WIDTH-1:0]    alu_res;
  logic [WIDTH-1:0]    st_val_out;
  logic                wb_en_out;
  logic                mem_read_out;
  logic                mem_write_out;
  logic [REG_BITS-1:0] dest_out;
  logic                valid_out;
  logic [3:0]          status;

  modport master (
    output freeze, flush, valid_in, exe_cmd, s_in, wb_en_in, mem_read_in,
           mem_write_in, dest_in, val_rn, val_2,
    input  alu_res, st_val_out, wb_en_out, mem_read_out, mem_write_out,
           dest_out, valid_out, status
  );

  modport slave (
    input  freeze, flush, valid_in, exe_cmd, s_in, wb_en_in, mem_read_in,
           mem_write_in, dest_in, val_rn, val_2,
    output alu_res, st_val_out, wb_en_out, mem_read_out, mem_write_out,
           dest_out, valid_out, status
  );
endinterface

// File: rtl/exe_alu_status.sv
// Execute stage: ALU plus NZCV status register, feeding the EXE/MEM pipeline
// register with freeze (hold) and flush (bubble) control.
module exe_alu_status #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_BITS = 4
) (
  input logic clk,
  input logic rst,
  exe_alu_status_if.slave bus
);

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } cmd_e;

  logic [WIDTH-1:0]    alu_res_q, alu_res_d;
  logic [WIDTH-1:0]    st_val_q, st_val_d;
  logic                wb_en_q, wb_en_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [REG_BITS-1:0] dest_q, dest_d;
  logic                valid_q, valid_d;
  logic [3:0]          status_q, status_d;

  logic [WIDTH-1:0]    res;
  logic [WIDTH-1:0]    op_b;
  logic [WIDTH:0]      sum;
  logic                cin;
  logic                arith;
  logic                defined;
  logic                ovf;
  logic [3:0]          new_flags;

  always_comb begin
    res     = '0;
    op_b    = bus.val_2;
    cin     = 1'b0;
    arith   = 1'b0;
    defined = 1'b1;
    unique case (bus.exe_cmd)
      CMD_MOV: res = bus.val_2;
      CMD_MVN: res = ~bus.val_2;
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin arith = 1'b1; cin = status_q[1]; end
      CMD_SUB: begin arith = 1'b1; op_b = ~bus.val_2; cin = 1'b1; end
      CMD_SBC: begin arith = 1'b1; op_b = ~bus.val_2; cin = status_q[1]; end
      CMD_AND: res = bus.val_rn & bus.val_2;
      CMD_ORR: res = bus.val_rn | bus.val_2;
      CMD_EOR: res = bus.val_rn ^ bus.val_2;
      default: defined = 1'b0;
    endcase
    // Subtract is rn + ~val_2 + cin, so carry out is directly NOT borrow.
    sum = {1'b0, bus.val_rn} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
    if (arith) res = sum[WIDTH-1:0];
    ovf = (bus.val_rn[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != bus.val_rn[WIDTH-1]);
    new_flags = {res[WIDTH-1], (res == '0),
                 arith ? sum[WIDTH] : status_q[1],
                 arith ? ovf        : status_q[0]};
  end

  always_comb begin
    alu_res_d   = alu_res_q;
    st_val_d    = st_val_q;
    wb_en_d     = wb_en_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    dest_d      = dest_q;
    valid_d     = valid_q;
    status_d    = status_q;
    if (bus.flush) begin
      alu_res_d   = '0;
      st_val_d    = '0;
      wb_en_d     = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      dest_d      = '0;
      valid_d     = 1'b0;
    end else if (!bus.freeze) begin
      alu_res_d   = res;
      st_val_d    = bus.val_2;
      wb_en_d     = bus.valid_in & bus.wb_en_in;
      mem_read_d  = bus.valid_in & bus.mem_read_in;
      mem_write_d = bus.valid_in & bus.mem_write_in;
      dest_d      = bus.dest_in;
      valid_d     = bus.valid_in;
      if (bus.valid_in && bus.s_in && defined) status_d = new_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_res_q   <= '0;
      st_val_q    <= '0;
      wb_en_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      dest_q      <= '0;
      valid_q     <= 1'b0;
      status_q    <= '0;
    end else begin
      alu_res_q   <= alu_res_d;
      st_val_q    <= st_val_d;
      wb_en_q     <= wb_en_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      dest_q      <= dest_d;
      valid_q     <= valid_d;
      status_q    <= status_d;
    end
  end

  assign bus.alu_res       = alu_res_q;
  assign bus.st_val_out    = st_val_q;
  assign bus.wb_en_out     = wb_en_q;
  assign bus.mem_read_out  = mem_read_q;
  assign bus.mem_write_out = mem_write_q;
  assign bus.dest_out      = dest_q;
  assign bus.valid_out     = valid_q;
  assign bus.status        = status_q;

endmodule

// File: tb/tb_exe_alu_status.sv
// Scoreboard bench for exe_alu_status: driver pushes model predictions, monitor pops and compares.
module tb_exe_alu_status;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_alu_status_if #(.WIDTH(32), .REG_BITS(4)) bus ();

  exe_alu_status #(.WIDTH(32), .REG_BITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [3:0]  dest;
    logic        valid;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [3:0]  status;
  } out_t;

  typedef struct {
    out_t o;
    bit   data_known;
    int   idx;
  } exp_t;

  exp_t q[$];
  out_t m_out;
  bit   m_known;
  int   checks = 0;
  int   failures = 0;
  int   issued = 0;

  // Reference: arithmetic done in 64-bit integers, flags from numeric ranges.
  task automatic drive(input bit rs, input bit fl, input bit fz, input bit vi,
                       input logic [3:0] cmd, input bit s, input bit wb,
                       input bit mr, input bit mw, input logic [3:0] d,
                       input logic [31:0] rn, input logic [31:0] v2);
    longint unsigned ua, ub, full;
    longint          sa, sb, ss;
    logic [31:0]     r;
    logic [3:0]      st;
    bit              c, arith, def, cout, vflag;
    exp_t            e;
    @(negedge clk);
    rst = rs; bus.flush = fl; bus.freeze = fz; bus.valid_in = vi;
    bus.exe_cmd = cmd; bus.s_in = s; bus.wb_en_in = wb; bus.mem_read_in = mr;
    bus.mem_write_in = mw; bus.dest_in = d; bus.val_rn = rn; bus.val_2 = v2;

    st = m_out.status;
    c = st[1];
    ua = {32'd0, rn}; ub = {32'd0, v2};
    sa = longint'($signed(rn)); sb = longint'($signed(v2));
    arith = 1'b0; def = 1'b1; cout = 1'b0; vflag = 1'b0; r = 32'd0;
    case (cmd)
      4'd1: r = v2;
      4'd9: r = ~v2;
      4'd2, 4'd3: begin
        arith = 1'b1;
        full = ua + ub + ((cmd == 4'd3) ? longint'(c) : 0);
        ss   = sa + sb + ((cmd == 4'd3) ? longint'(c) : 0);
        r = full[31:0]; cout = (full >= 64'h1_0000_0000);
        vflag = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        longint unsigned bw;
        bw = (cmd == 4'd5) ? longint'(!c) : 0;
        arith = 1'b1;
        full = ua - ub - bw;
        ss   = sa - sb - longint'(bw);
        r = full[31:0]; cout = (ua >= ub + bw);
        vflag = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd6: r = rn & v2;
      4'd7: r = rn | v2;
      4'd8: r = rn ^ v2;
      default: def = 1'b0;
    endcase

    if (rs) begin
      m_out = '0; m_known = 1'b1;
    end else if (fl) begin
      m_out.alu_res = 0; m_out.st_val = 0; m_out.dest = 0;
      m_out.valid = 0; m_out.wb = 0; m_out.mr = 0; m_out.mw = 0;
      m_known = 1'b1;
    end else if (!fz) begin
      m_out.alu_res = r; m_out.st_val = v2; m_out.dest = d;
      m_out.valid = vi; m_out.wb = vi & wb; m_out.mr = vi & mr; m_out.mw = vi & mw;
      m_known = vi;
      if (vi && s && def)
        m_out.status = {r[31], (r == 32'd0), arith ? cout : st[1], arith ? vflag : st[0]};
    end
    e.o = m_out; e.data_known = m_known; e.idx = issued;
    q.push_back(e);
    issued++;
  endtask

  task automatic op(input logic [3:0] cmd, input bit s, input bit wb, input bit mr,
                    input bit mw, input logic [31:0] rn, input logic [31:0] v2);
    drive(0, 0, 0, 1, cmd, s, wb, mr, mw, 4'($urandom_range(0, 15)), rn, v2);
  endtask

  // Monitor: every edge yields one registered output word.
  initial begin
    exp_t e;
    out_t a, m;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {bus.alu_res, bus.st_val_out, bus.dest_out, bus.valid_out, bus.wb_en_out,
             bus.mem_read_out, bus.mem_write_out, bus.status};
        m = e.data_known ? '1 : {32'd0, 32'd0, 4'd0, 8'hFF};
        checks++;
        if ((a & m) !== (e.o & m)) begin
          failures++;
          $display("FAIL cycle_%0d: actual res=%h st=%h dest=%h v/wb/mr/mw=%b%b%b%b nzcv=%b required res=%h st=%h dest=%h v/wb/mr/mw=%b%b%b%b nzcv=%b",
                   e.idx, a.alu_res, a.st_val, a.dest, a.valid, a.wb, a.mr, a.mw, a.status,
                   e.o.alu_res, e.o.st_val, e.o.dest, e.o.valid, e.o.wb, e.o.mr, e.o.mw, e.o.status);
        end
      end
    end
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_out = '0; m_known = 1'b1;
    rst = 1'b1;
    bus.flush = 0; bus.freeze = 0; bus.valid_in = 0; bus.exe_cmd = 0; bus.s_in = 0;
    bus.wb_en_in = 0; bus.mem_read_in = 0; bus.mem_write_in = 0; bus.dest_in = 0;
    bus.val_rn = 0; bus.val_2 = 0;

    // Reset with random inputs on the other pins
    for (int i = 0; i < 2; i++)
      drive(1, $urandom, $urandom, $urandom, 4'($urandom), $urandom, $urandom,
            $urandom, $urandom, 4'($urandom), $urandom, $urandom);

    op(4'd2, 1, 1, 0, 0, 32'hFFFF_FFFF, 32'd1);          // ADDS -> 0, Z C
    op(4'd4, 1, 1, 0, 0, 32'h8000_0000, 32'd1);          // SUBS -> C V
    op(4'd3, 0, 1, 0, 0, 32'd1, 32'd1);                  // ADC uses C=1 -> 3
    op(4'd4, 1, 0, 0, 0, 32'd5, 32'd5);                  // CMP -> Z C
    op(4'd2, 0, 0, 0, 1, 32'h100, 32'h8);                // STR address
    op(4'd2, 1, 1, 0, 0, 32'h7FFF_FFFF, 32'd1);          // ADDS overflow
    op(4'd3, 1, 1, 0, 0, 32'hFFFF_FFFF, 32'd0);          // ADCS with C=0
    op(4'd5, 1, 1, 0, 0, 32'd3, 32'd3);                  // SBCS C=0 -> -1
    op(4'd6, 1, 1, 0, 0, 32'hF0F0_0000, 32'h0F0F_0000);  // ANDS -> Z, C/V kept
    op(4'd9, 1, 1, 0, 0, 32'd0, 32'd0);                  // MVNS -> N
    op(4'd0, 1, 1, 0, 0, 32'd7, 32'd9);                  // undefined: res 0, flags kept
    op(4'd2, 0, 1, 1, 0, 32'h200, 32'h4);                // LDR
    for (int i = 0; i < 3; i++)
      drive(0, 0, 1, 1, 4'd2, 1, 1, 0, 0, 4'($urandom), 32'hFFFF_FFFF, 32'd1);
    drive(0, 1, 1, 1, 4'd6, 1, 1, 0, 0, 4'd3, 32'd0, 32'd0);       // flush+freeze ANDS
    drive(0, 0, 0, 0, 4'd2, 1, 1, 1, 1, 4'd5, 32'd1, 32'd1);       // bubble, no flags

    for (int i = 0; i < 300; i++) begin
      int unsigned rr;
      rr = $urandom_range(0, 99);
      drive(rr < 2, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 99) < 85),
            ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 9)),
            $urandom, $urandom, $urandom, $urandom, 4'($urandom),
            rand_operand(), rand_operand());
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: actual pending=%0d required pending=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
